// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store fields into a req/ack
// data-memory transaction, stalls the pipeline until ack, and extends load data.
module mem_access_unit #(
    parameter int DATA_WIDTH          = 32,
    parameter int DATA_ADDR_WIDTH     = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_EX_MEM_o,
    input  logic                       mem_write_EX_MEM_o,
    input  logic                       mem_read_EX_MEM_o,
    input  logic [2:0]                 funct3_EX_MEM_o,
    input  logic [DATA_ADDR_WIDTH-1:0] alu_res_EX_MEM_o,
    input  logic [DATA_WIDTH-1:0]      write_data_EX_MEM_o,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]                 dmem_wstrb,
    output logic [DATA_WIDTH-1:0]      dmem_wdata,
    input  logic                       dmem_ack,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata,
    output logic                       stall_MEM,
    output logic [DATA_WIDTH-1:0]      read_data_MEM,
    output logic                       read_valid_MEM,
    output logic                       misalign_MEM
);

    if (DATA_WIDTH != 32 || REGISTER_ADDR_WIDTH < 1) begin : g_bad_param
        $error("mem_access_unit supports DATA_WIDTH == 32 only");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       req_q, req_d;
    logic                       we_q, we_d;
    logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]                 wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [2:0]                 f3_q, f3_d;
    logic [1:0]                 off_q, off_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       rvalid_q, rvalid_d;

    logic                  access, misal;
    logic [1:0]            off;
    logic [3:0]            st_strb;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH-1:0] shifted, load_ext;

    always_comb begin
        off     = alu_res_EX_MEM_o[1:0];
        access  = valid_EX_MEM_o & (mem_read_EX_MEM_o | mem_write_EX_MEM_o);
        misal   = 1'b0;
        st_strb = 4'b1111;
        st_data = write_data_EX_MEM_o;
        case (funct3_EX_MEM_o[1:0])
            2'b00: begin
                st_strb = 4'b0001 << off;
                st_data = {(DATA_WIDTH/8){write_data_EX_MEM_o[7:0]}};
            end
            2'b01: begin
                misal   = off[0];
                st_strb = 4'b0011 << off;
                st_data = {(DATA_WIDTH/16){write_data_EX_MEM_o[15:0]}};
            end
            2'b10:   misal = (off != 2'b00);
            default: misal = 1'b1;
        endcase
    end

    // Load extraction works on the captured offset/funct3, not the live inputs.
    always_comb begin
        shifted  = dmem_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (f3_q[1:0])
            2'b00: load_ext = f3_q[2] ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                      : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = f3_q[2] ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                      : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && !misal) begin
                    state_d = S_BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_write_EX_MEM_o;
                    addr_d  = {alu_res_EX_MEM_o[DATA_ADDR_WIDTH-1:2], 2'b00};
                    wstrb_d = mem_write_EX_MEM_o ? st_strb : 4'b0000;
                    wdata_d = mem_write_EX_MEM_o ? st_data : '0;
                    f3_d    = funct3_EX_MEM_o;
                    off_d   = off;
                end
            end
            S_BUSY: begin
                if (dmem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d  = load_ext;
                        rvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= '0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wstrb     = wstrb_q;
    assign dmem_wdata     = wdata_q;
    assign read_data_MEM  = rdata_q;
    assign read_valid_MEM = rvalid_q;
    assign stall_MEM      = ((state_q == S_IDLE) && access && !misal) || (state_q == S_BUSY);
    assign misalign_MEM   = (state_q == S_IDLE) && access && misal;

endmodule
